// File: rtl/demux8_feed_sequencer_if.sv
// ----------------------------------------------------------------------------
// demux8_feed_sequencer_if: valid/ready request channel carrying {channel, bit}.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface demux8_feed_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_ch;
  logic       in_bit;

  modport master (output in_valid, output in_ch, output in_bit, input in_ready);
  modport slave  (input in_valid, input in_ch, input in_bit, output in_ready);
endinterface

`default_nettype wire

// File: rtl/demux8_feed_sequencer.sv
// ----------------------------------------------------------------------------
// demux8_feed_sequencer: buffers (channel, bit) requests and drives a 1:8 demux
// with timed, glitch-free select/data pulses. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module demux8_feed_sequencer #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 3,
  parameter int GAP   = 1
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  demux8_feed_sequencer_if.slave          req,
  output logic                            a,
  output logic                            s0,
  output logic                            s1,
  output logic                            s2,
  output logic                            strobe,
  output logic                            busy,
  output logic [$clog2(DEPTH+1)-1:0]      level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [3:0] HOLD_LD = 4'(HOLD - 1);
  localparam logic [3:0] GAP_LD  = 4'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  logic [3:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             a_q, a_d;
  logic [2:0]       sel_q, sel_d;
  logic             strobe_q, strobe_d;

  logic       push;
  logic       load;
  logic       empty;
  logic [3:0] head;

  // No push-through when full: ready depends only on current occupancy.
  assign req.in_ready = (level_q != FULL_LVL);
  assign push         = req.in_valid && req.in_ready;
  assign empty        = (level_q == '0);
  assign head         = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req.in_ch, req.in_bit};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    sel_d    = sel_q;
    strobe_d = strobe_q;
    load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty) load = 1'b1;
      end
      ST_DRIVE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          a_d      = 1'b0;
          strobe_d = 1'b0;
          if (GAP > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LD;
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (!empty) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Selects only ever move here, together with the rising strobe.
    if (load) begin
      state_d  = ST_DRIVE;
      cnt_d    = HOLD_LD;
      sel_d    = head[3:1];
      a_d      = head[0];
      strobe_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = load ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    level_d  = level_q + LVL_W'(push) - LVL_W'(load);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      a_q      <= 1'b0;
      sel_q    <= 3'd0;
      strobe_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      sel_q    <= sel_d;
      strobe_q <= strobe_d;
    end
  end

  assign a            = a_q;
  assign {s2, s1, s0} = sel_q;
  assign strobe       = strobe_q;
  assign busy         = (state_q != ST_IDLE) || !empty;
  assign level        = level_q;

endmodule

`default_nettype wire

// File: doc/demux8_feed_sequencer.md
Name: demux8_feed_sequencer

Overview:
- Upstream stage for the team's 1:8 demultiplexer; drives its data bit `a` and selects `s0`/`s1`/`s2`.
- Accepts (channel, bit) requests on a valid/ready interface and buffers them in a small FIFO.
- Presents each request to the demux for a fixed number of cycles, followed by an optional idle gap.
- Ensures each demux output sees a clean, timed pulse, with no select changes while `a` is high.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- HOLD, 3, cycles each entry is driven; 1..15.
- GAP, 1, idle cycles after each entry, during which `a`=0; 0..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  FIFO can accept; equals !full.
- in_ch  input  3  target channel 0..7.
- in_bit  input  1  data bit for the target channel.
- a  output  1  demux data input.
- s0  output  1  select bit 0 (LSB).
- s1  output  1  select bit 1.
- s2  output  1  select bit 2 (MSB).
- strobe  output  1  high while an entry is being driven (DRIVE state).
- busy  output  1  state != IDLE or FIFO not empty.
- level  output  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): state=IDLE; FIFO empty; pointers=0; a=0; s2,s1,s0=000; strobe=0; busy=0; level=0. in_ready=1, but pushes are ignored while rst_n=0.
- Push: occurs on a rising edge with in_valid && in_ready; stores {in_ch,in_bit}. When full, in_ready=0 even if a pop happens in the same cycle; there is no push-through-when-full.
- Pointers wrap modulo DEPTH. level = pushes - pops. Simultaneous push and pop leaves level unchanged.
- Outputs a, s*, strobe are registered.
- State machine (IDLE, DRIVE, GAP), with a hold/gap counter:
  - IDLE: if FIFO non-empty at an edge, pop the head, load {s2,s1,s0}=ch and a=bit, set strobe=1, go to DRIVE, counter=HOLD-1.
  - DRIVE: outputs held stable. While counter!=0, decrement. At counter==0 the next edge does a=0, strobe=0, with s unchanged:
    - GAP>0: go to GAP with counter=GAP-1.
    - GAP==0: if FIFO non-empty, pop and reload directly to DRIVE (back-to-back); else go to IDLE.
  - GAP: a=0, strobe=0, s holds the last channel. At counter==0 the next edge goes to IDLE. If FIFO non-empty, it instead pops directly into DRIVE with the same load as IDLE.
- Latency: a push at edge N into an empty, idle block gives strobe/a/s valid after edge N+1.
- Each entry is driven for exactly HOLD cycles.
- Entry period is HOLD+GAP cycles, or HOLD cycles when GAP=0.
- An entry with bit=0 still produces strobe for HOLD cycles with a=0.
- Selects change only on the DRIVE-load edge, never mid-entry.
- Mid-operation reset: everything returns immediately to reset values, and buffered entries are discarded.
- in_ch/in_bit are sampled only on push; they are don't-care otherwise.

Test Plan:
- Single request: push ch=5,bit=1 at edge 0 (HOLD=3,GAP=1) → cycles 1-3: s2s1s0=101,a=1,strobe=1; cycle 4: a=0,strobe=0,s=101; cycle 5: IDLE, busy=0.
- Sweep: push ch=0..7, bit=1 in order (channel loop) → each channel driven 3 cycles with a=1, 1-cycle gaps, total 32 cycles; the demux's y walks one-hot 00000001→10000000.
- Backpressure: hold in_valid=1 for 8 cycles with DEPTH=4 → in_ready drops when level=4. No entry is lost or duplicated; output order matches acceptance order; level never exceeds 4.
- GAP=0 back-to-back: push ch=2,bit=1 then ch=6,bit=1 → s=010 for 3 cycles, then immediately s=110 for 3 cycles; strobe continuously 1 for 6 cycles.
- Zero bit: push ch=3,bit=0 → strobe=1 for 3 cycles with s=011 and a=0 throughout.
- Reset mid-drive: assert rst_n=0 during DRIVE with 2 entries queued → a=0, s=000, strobe=0, level=0 asynchronously. After release, no output activity occurs until a new push.
- Wrap: push/pop 10 entries through DEPTH=4 with random channels → output sequence matches input exactly.
